// File: rtl/wave_rom_pkg.sv
// Shared types and helpers for the wavetable ROM reader.
// Holds the channel state encoding and channel-tag width rule.
package wave_rom_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wave_rom_core.sv
// Synchronous single-port ROM with a one-cycle registered read.
// The table holds word n = n.
module wave_rom_core #(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    DATA_WIDTH  = 32,
  parameter string INIT_FILE   = "NONE",
  parameter string INIT_FORMAT = "BIN"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  initial begin
    for (int i = 0; i < 2**ADDR_WIDTH; i++) begin
      mem[i] = DATA_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= mem[addr];
    end
  end

endmodule

// File: rtl/wave_rom_reader.sv
// Multi-channel phase-accumulator reader of a shared wavetable ROM.
// One channel per slot, round-robin; one-shot or looping playback.
module wave_rom_reader
  import wave_rom_pkg::*;
#(
  parameter int    ADDR_WIDTH  = 10,
  parameter int    DATA_WIDTH  = 32,
  parameter int    CH_NUM      = 4,
  parameter int    PHASE_WIDTH = 24,
  parameter int    OUTPUT_REG  = 0,
  parameter string INIT_FILE   = "NONE",
  parameter string INIT_FORMAT = "BIN"
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clk_en,
  input  logic [CH_NUM-1:0]             start,
  input  logic [CH_NUM-1:0]             stop,
  input  logic [CH_NUM-1:0]             one_shot,
  input  logic [CH_NUM*PHASE_WIDTH-1:0] freq_word,
  output logic [CH_NUM-1:0]             busy,
  output logic [CH_NUM-1:0]             done,
  output logic                          rd_valid,
  output logic [ch_w(CH_NUM)-1:0]       rd_ch,
  output logic [DATA_WIDTH-1:0]         rd_data
);

  localparam int CW = ch_w(CH_NUM);
  localparam int PW = PHASE_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam logic [CW-1:0] LAST = CW'(CH_NUM - 1);

  ch_state_e         state_q [CH_NUM];
  ch_state_e         state_d [CH_NUM];
  logic [PW-1:0]     phase_q [CH_NUM];
  logic [PW-1:0]     phase_d [CH_NUM];
  logic [PW:0]       sum     [CH_NUM];
  logic [CH_NUM-1:0] done_d;
  logic [CW-1:0]     slot_q;
  logic              issue;
  logic [AW-1:0]     addr;
  logic              v1;
  logic [CW-1:0]     ch1;
  logic [DATA_WIDTH-1:0] q;

  always_comb begin
    issue  = 1'b0;
    addr   = '0;
    done_d = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      state_d[c] = state_q[c];
      phase_d[c] = phase_q[c];
      sum[c] = {1'b0, phase_q[c]}
             + {1'b0, freq_word[c*PW +: PW]};
      if (state_q[c] == RUN && slot_q == CW'(c)) begin
        issue      = 1'b1;
        addr       = phase_q[c][PW-1 -: AW];
        phase_d[c] = sum[c][PW-1:0];
        if (one_shot[c] && sum[c][PW]) begin
          state_d[c] = IDLE;
          done_d[c]  = 1'b1;
        end
      end
      // Stop beats start; either one cancels a completion.
      if (stop[c]) begin
        state_d[c] = IDLE;
        done_d[c]  = 1'b0;
      end else if (start[c]) begin
        state_d[c] = RUN;
        phase_d[c] = '0;
        done_d[c]  = 1'b0;
      end
    end
  end

  always_comb begin
    for (int c = 0; c < CH_NUM; c++) begin
      busy[c] = (state_q[c] == RUN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      done   <= '0;
      v1     <= 1'b0;
      ch1    <= '0;
      for (int c = 0; c < CH_NUM; c++) begin
        state_q[c] <= IDLE;
        phase_q[c] <= '0;
      end
    end else if (clk_en) begin
      slot_q <= (slot_q == LAST) ? '0 : slot_q + 1'b1;
      done   <= done_d;
      v1     <= issue;
      ch1    <= slot_q;
      for (int c = 0; c < CH_NUM; c++) begin
        state_q[c] <= state_d[c];
        phase_q[c] <= phase_d[c];
      end
    end
  end

  wave_rom_core #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DATA_WIDTH),
    .INIT_FILE   (INIT_FILE),
    .INIT_FORMAT (INIT_FORMAT)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (clk_en & issue),
    .addr  (addr),
    .q     (q)
  );

  if (OUTPUT_REG != 0) begin : g_oreg
    logic                  v2;
    logic [CW-1:0]         ch2;
    logic [DATA_WIDTH-1:0] d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v2  <= 1'b0;
        ch2 <= '0;
        d2  <= '0;
      end else if (clk_en) begin
        v2  <= v1;
        ch2 <= ch1;
        if (v1) begin
          d2 <= q;
        end
      end
    end

    assign rd_valid = v2;
    assign rd_ch    = ch2;
    assign rd_data  = d2;
  end else begin : g_direct
    assign rd_valid = v1;
    assign rd_ch    = ch1;
    assign rd_data  = q;
  end

endmodule
